// File: rtl/mbist_1500_wrapper.sv
// IEEE 1500 wrapped MBIST engine (MATS+ / March C-) with functional/BIST SRAM port mux.
// Engine ops issue one per cycle in RUN; read compares complete one cycle later (DRAIN covers the last).
module mbist_1500_wrapper #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              csb0_ext,
  input  logic              web0_ext,
  input  logic [ADDR_W-1:0] addr0_ext,
  input  logic [DATA_W-1:0] din0_ext,
  output logic [DATA_W-1:0] dout0_ext,
  output logic              csb0,
  output logic              web0,
  output logic [ADDR_W-1:0] addr0,
  output logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] dout0,
  input  logic              wsi,
  output logic              wso,
  input  logic              select_wir,
  input  logic              capture_wr,
  input  logic              shift_wr,
  input  logic              update_wr,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_pass
);

  localparam int SW = FCNT_W + ADDR_W + 2;
  localparam logic [2:0] I_CFG    = 3'b001;
  localparam logic [2:0] I_STATUS = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic down;
    logic two;
    logic op0_rd;
    logic op0_val;
    logic op1_val;
    logic last;
  } elem_t;

  logic [2:0]        wir_sh, wir_q;
  logic [3:0]        cfg_sh, cfg_q;
  logic [SW-1:0]     st_sh;
  logic              wby;
  state_t            state, state_nxt;
  logic [1:0]        alg_q;
  logic [2:0]        elem_q;
  logic              opi_q;
  logic [ADDR_W-1:0] addr_q, raddr_q;
  logic              rd_pend, exp_q;
  logic [FCNT_W-1:0] fail_cnt;
  logic [ADDR_W-1:0] ffa;
  logic              done_r, pass_r;

  function automatic logic elem_down(input logic alg, input logic [2:0] e);
    elem_down = alg ? (e == 3'd3 || e == 3'd4) : (e == 3'd2);
  endfunction

  // Element table: alg=0 MATS+, alg=1 March C-; two-op elements are read-then-write per address.
  function automatic elem_t elem_dec(input logic alg, input logic [2:0] e);
    elem_t d;
    d = '0;
    d.down = elem_down(alg, e);
    d.last = 1'b1;
    if (!alg) begin
      case (e)
        3'd0: d.last = 1'b0;
        3'd1: begin d.two = 1'b1; d.op0_rd = 1'b1; d.op1_val = 1'b1; d.last = 1'b0; end
        3'd2: begin d.two = 1'b1; d.op0_rd = 1'b1; d.op0_val = 1'b1; end
        default: ;
      endcase
    end else begin
      case (e)
        3'd0: d.last = 1'b0;
        3'd1, 3'd3: begin d.two = 1'b1; d.op0_rd = 1'b1; d.op1_val = 1'b1; d.last = 1'b0; end
        3'd2, 3'd4: begin d.two = 1'b1; d.op0_rd = 1'b1; d.op0_val = 1'b1; d.last = 1'b0; end
        3'd5: d.op0_rd = 1'b1;
        default: ;
      endcase
    end
    return d;
  endfunction

  logic sel_cfg, sel_st, sel_by, update_act, start_req, dis_req;
  assign sel_cfg    = !select_wir && (wir_q == I_CFG);
  assign sel_st     = !select_wir && (wir_q == I_STATUS);
  assign sel_by     = !select_wir && !sel_cfg && !sel_st;
  assign update_act = update_wr && !capture_wr && !shift_wr;
  assign start_req  = update_act && sel_cfg && cfg_sh[1] && cfg_sh[0];
  assign dis_req    = update_act && sel_cfg && !cfg_sh[0];

  // WSP shift/shadow registers; the start bit is never stored in the CFG shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wir_sh <= '0;
      wir_q  <= '0;
      cfg_sh <= '0;
      cfg_q  <= '0;
      st_sh  <= '0;
      wby    <= 1'b0;
    end else begin
      if (select_wir) begin
        if (capture_wr)     wir_sh <= wir_q;
        else if (shift_wr)  wir_sh <= {wsi, wir_sh[2:1]};
        else if (update_wr) wir_q  <= wir_sh;
      end
      if (sel_cfg) begin
        if (capture_wr)     cfg_sh <= cfg_q;
        else if (shift_wr)  cfg_sh <= {wsi, cfg_sh[3:1]};
        else if (update_wr) cfg_q  <= {cfg_sh[3:2], 1'b0, cfg_sh[0]};
      end
      if (sel_st) begin
        if (capture_wr)     st_sh <= {fail_cnt, ffa, done_r, pass_r};
        else if (shift_wr)  st_sh <= {wsi, st_sh[SW-1:1]};
      end
      if (sel_by) begin
        if (capture_wr)     wby <= 1'b0;
        else if (shift_wr)  wby <= wsi;
      end
    end
  end

  always_comb begin
    wso = wby;
    if (select_wir)   wso = wir_sh[0];
    else if (sel_cfg) wso = cfg_sh[0];
    else if (sel_st)  wso = st_sh[0];
  end

  elem_t             cur;
  logic              op_go, op_rd, op_val, step_end, addr_last, last_op, nxt_down, mis;
  assign cur       = elem_dec(alg_q[0], elem_q);
  assign nxt_down  = elem_down(alg_q[0], elem_q + 3'd1);
  assign op_go     = (state == S_RUN) && !alg_q[1];
  assign op_rd     = opi_q ? 1'b0 : cur.op0_rd;
  assign op_val    = opi_q ? cur.op1_val : cur.op0_val;
  assign step_end  = !cur.two || opi_q;
  assign addr_last = cur.down ? (addr_q == '0) : (addr_q == '1);
  assign last_op   = step_end && addr_last && cur.last;
  assign mis       = rd_pend && (state == S_RUN || state == S_DRAIN) &&
                     (dout0 != {DATA_W{exp_q}});

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_req) state_nxt = S_RUN;
      S_RUN: begin
        if (alg_q[1])     state_nxt = S_DONE;
        else if (last_op) state_nxt = S_DRAIN;
      end
      S_DRAIN: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    if (dis_req) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      alg_q    <= '0;
      elem_q   <= '0;
      opi_q    <= 1'b0;
      addr_q   <= '0;
      raddr_q  <= '0;
      rd_pend  <= 1'b0;
      exp_q    <= 1'b0;
      fail_cnt <= '0;
      ffa      <= '0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_pend <= op_go && op_rd;
      exp_q   <= op_val;
      raddr_q <= addr_q;
      if (start_req && (state == S_IDLE || state == S_DONE)) begin
        alg_q    <= cfg_sh[3:2];
        elem_q   <= '0;
        opi_q    <= 1'b0;
        addr_q   <= '0;
        fail_cnt <= '0;
        ffa      <= '0;
        done_r   <= 1'b0;
        pass_r   <= 1'b0;
      end else begin
        if (op_go) begin
          if (step_end) begin
            opi_q <= 1'b0;
            if (addr_last) begin
              elem_q <= elem_q + 3'd1;
              addr_q <= nxt_down ? '1 : '0;
            end else begin
              addr_q <= cur.down ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
            end
          end else begin
            opi_q <= 1'b1;
          end
        end
        if (mis) begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + FCNT_W'(1);
          if (fail_cnt == '0) ffa <= raddr_q;
        end
        // The DRAIN compare lands on the same edge as the pass decision, so fold it in.
        if (!dis_req && state == S_DRAIN) begin
          done_r <= 1'b1;
          pass_r <= (fail_cnt == '0) && !mis;
        end else if (!dis_req && state == S_RUN && alg_q[1]) begin
          done_r <= 1'b1;
          pass_r <= 1'b0;
        end
      end
    end
  end

  assign bist_busy = (state == S_RUN) || (state == S_DRAIN);
  assign bist_done = done_r;
  assign bist_pass = pass_r;
  assign dout0_ext = dout0;

  always_comb begin
    csb0  = csb0_ext;
    web0  = web0_ext;
    addr0 = addr0_ext;
    din0  = din0_ext;
    if (cfg_q[0]) begin
      csb0  = !op_go;
      web0  = !(op_go && !op_rd);
      addr0 = addr_q;
      din0  = {DATA_W{op_val}};
    end
  end

endmodule

// File: doc/mbist_1500_wrapper.md
MBIST_1500_WRAPPER -- requirements
Module: mbist_1500_wrapper

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning SRAM address width (depth N = 2^ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 32, meaning SRAM data width.
REQ-003 SHALL have parameter FCNT_W, default 8, meaning fail-counter width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with the ports listed below.
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- csb0_ext, web0_ext  in  1  functional chip-select and write-enable (active low).
- addr0_ext  in  ADDR_W  functional address.
- din0_ext  in  DATA_W  functional write data.
- dout0_ext  out  DATA_W  SRAM read data, passed through.
- csb0, web0  out  1  SRAM-side controls.
- addr0  out  ADDR_W  SRAM-side address.
- din0  out  DATA_W  SRAM-side write data.
- dout0  in  DATA_W  SRAM read data, valid the cycle after a read issue.
- wsi  in  1  IEEE 1500 serial input.
- wso  out  1  IEEE 1500 serial output.
- select_wir, capture_wr, shift_wr, update_wr  in  1  WSP controls.
- bist_busy, bist_done, bist_pass  out  1  MBIST status.

Function
REQ-005 SHALL implement a 3-bit WIR with these instructions: 000 BYPASS (1-bit WBY), 001 CFG, 010 STATUS; all other codes SHALL act as BYPASS.
REQ-006 SHALL make the CFG register 4 bits: [0] mbist_en, [1] start, [3:2] alg; alg 00 selects MATS+, 01 selects March C-, 1x is reserved.
REQ-007 SHALL make the STATUS register {fail_cnt[FCNT_W], first_fail_addr[ADDR_W], done, pass}, with pass as the LSB; it SHALL be capture-only.
REQ-008 SHALL address the WIR when select_wir=1 and the WDR chosen by the WIR otherwise; wso SHALL be the LSB of the addressed shift register, and shifting SHALL be right-shift with wsi entering at the MSB.
REQ-009 SHALL apply WSP priority capture > shift > update; only one action per cycle.
REQ-010 SHALL, on update, load the shadow WIR or CFG from the shift stage; the start bit SHALL be a one-shot that never stays set in the shadow.
REQ-011 SHALL drive the SRAM from the functional ports when shadow mbist_en=0, and from the engine otherwise.
REQ-012 SHALL implement an FSM with states IDLE, RUN, DRAIN, DONE.
- IDLE->RUN: CFG update with start=1 and mbist_en=1.
- RUN->DRAIN: after the last op.
- DRAIN->DONE: after 1 cycle.
- DONE->RUN: on a new start.
- Any state->IDLE: CFG update with mbist_en=0.
REQ-013 SHALL issue exactly one SRAM op per cycle in RUN, with the first op in the cycle after the update.
REQ-014 SHALL execute MATS+ as: up-or-down(w0); up(r0,w1); down(r1,w0), for 5N ops.
REQ-015 SHALL execute March C- as: (w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); (r0), for 10N ops.
REQ-016 SHALL use an all-zeros background for 0 and all-ones for 1; "up" runs 0..N-1 and "down" runs N-1..0, with the address wrapping to start at each element boundary.
REQ-017 SHALL compare each read against its expected value in the following cycle, using a 1-cycle pipelined expect/address; the DRAIN state SHALL cover the final read.
REQ-018 SHALL, on a mismatch, increment fail_cnt (saturating at all-ones) and latch first_fail_addr only on the first mismatch of a run.
REQ-019 SHALL make a reserved alg go straight from RUN to DONE with zero SRAM ops, pass=0, and fail_cnt=0.
REQ-020 SHALL clear fail_cnt, first_fail_addr, done and pass when a run starts.
REQ-021 SHALL ignore a start received while in RUN.
REQ-022 SHALL assert bist_busy in RUN and DRAIN; bist_done and bist_pass SHALL be registered, with bist_pass = done AND fail_cnt==0.
REQ-023 SHALL hold csb0=1 in IDLE, DRAIN and DONE while mbist_en=1.

Reset
REQ-024 SHALL, on rst_n low and at any time including mid-run, immediately put the FSM in IDLE.
REQ-025 SHALL reset WIR, CFG, STATUS, WBY, fail_cnt and first_fail_addr to 0.
REQ-026 SHALL reset bist_busy, bist_done, bist_pass and wso to 0, and select functional mux mode.

Verification
REQ-027 SHALL cover: ADDR_W=4, fault-free SRAM model, CFG=0011 (MATS+) -> bist_busy for 81 cycles, bist_done=1 and bist_pass=1, STATUS captures fail_cnt=0.
REQ-028 SHALL cover: ADDR_W=4, CFG=0111 (March C-), bit 5 of addr 0x9 stuck-at-1 -> done=1, pass=0, first_fail_addr=0x9, fail_cnt=3.
REQ-029 SHALL cover: CFG with mbist_en=0 written mid-run -> IDLE next cycle, busy=0, done=0, functional write/read of 0xA5A5A5A5 at addr 3 round-trips.
REQ-030 SHALL cover: rst_n pulsed low mid-run -> all outputs 0 asynchronously, csb0 follows csb0_ext.
REQ-031 SHALL cover: WIR=000, shift 8 bits of 0xB4 on wsi -> identical stream on wso delayed by 1 cycle.
REQ-032 SHALL cover: CFG alg=10 with start -> done=1, pass=0, no SRAM op issued (csb0 stays 1).
